hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/stall controller for the 5-stage RV32 core; companion to the forwarding unit.
//  Forwarding cannot resolve three cases; this block sequences all three:
//   - load-use hazards: 1-cycle bubble.
//   - taken-branch flushes: BR_PENALTY cycles of IF/ID kill.
//   - memory back-pressure: whole-pipe freeze, with a wait watchdog.
//  Outputs drive PC / IF_ID write-enables, IF_ID / ID_EXE flush, and the global pipe hold.
// PARAMETERS
//  BR_PENALTY  2    cycles IF/ID is killed after a taken branch (1..7)
//  WAIT_MAX    255  mem_busy cycles before wait_timeout is set (1..255)
// PORTS
//  clk              in   1  core clock, rising edge
//  rst              in   1  synchronous reset, active-high
//  id_rs1_addr      in   5  rs1 of instruction in ID
//  id_rs2_addr      in   5  rs2 of instruction in ID
//  id_rs1_used      in   1  ID instruction reads rs1
//  id_rs2_used      in   1  ID instruction reads rs2
//  id_exe_mem_read  in   1  instruction in EXE is a load
//  id_exe_rd_addr   in   5  rd of instruction in EXE
//  exe_branch_taken in   1  EXE resolved taken branch/jump (1-cycle pulse)
//  mem_busy         in   1  IM or DM not ready this cycle
//  pc_write         out  1  PC register write enable
//  if_id_write      out  1  IF_ID register write enable
//  if_id_flush      out  1  load NOP into IF_ID
//  id_exe_flush     out  1  load bubble into ID_EXE
//  pipe_hold        out  1  freeze all pipeline regs incl. EXE_MEM, MEM_WB
//  wait_timeout     out  1  sticky: mem_busy held > WAIT_MAX consecutive cycles
// BEHAVIOUR
//  Reset (rst=1 at edge): state=RUN, flush_cnt=0, wait_cnt=0, wait_timeout=0.
//   While rst=1 outputs are forced to:
//    pc_write=0, if_id_write=0, if_id_flush=1, id_exe_flush=1, pipe_hold=0.
//  lu = id_exe_mem_read & id_exe_rd_addr!=0 &
//       ((id_rs1_used & id_rs1_addr==id_exe_rd_addr) | (id_rs2_used & id_rs2_addr==id_exe_rd_addr)).
//  Outputs are combinational from state + inputs (0-cycle latency).
//   Defaults: pc_write=1, if_id_write=1, all else 0.
//  Priority each cycle: mem_busy > exe_branch_taken > lu.
//  FSM states RUN, FLUSH, MEM_WAIT; ret_state register (RUN|FLUSH).
//   RUN:
//    - mem_busy: pipe_hold=1, pc_write=0, if_id_write=0; ret_state=RUN; ->MEM_WAIT.
//    - branch: if_id_flush=1, id_exe_flush=1; flush_cnt=BR_PENALTY-1.
//      ->FLUSH if BR_PENALTY>1, else stay RUN.
//    - lu: pc_write=0, if_id_write=0, id_exe_flush=1; stay RUN.
//      Next cycle the load is in MEM, so lu drops naturally.
//   FLUSH:
//    - mem_busy: hold as above; ret_state=FLUSH; flush_cnt frozen; ->MEM_WAIT.
//    - new branch: restart exactly as in RUN.
//    - else: if_id_flush=1; lu ignored (ID holds a NOP);
//      flush_cnt-=1; ->RUN when flush_cnt reaches 1.
//   MEM_WAIT:
//    - pipe_hold=1, pc_write=0, if_id_write=0 while mem_busy=1; branch and lu ignored.
//    - wait_cnt saturating +1 per cycle; when wait_cnt==WAIT_MAX, wait_timeout<=1.
//      wait_timeout clears only on rst.
//    - mem_busy=0: wait_cnt<=0; outputs decoded as in ret_state this cycle; ->ret_state.
//  A held exe_branch_taken is not lost: EXE is frozen, so the pulse re-presents on exit.
//  rst mid-flush or mid-wait: immediate return to reset state; no pending flush survives.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   - adds outputs perf_stall_cnt[31:0] (cycles with pipe_hold=1 or lu stall)
//     and perf_flush_cnt[31:0] (taken branches accepted).
//   - both 0 on rst; wrap modulo 2^32.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  T1 load x5 in EXE, ID reads rs2=x5 (rs2_used=1)
//     -> 1 cycle pc_write=0, if_id_write=0, id_exe_flush=1; next cycle normal.
//  T2 same as T1 but rd=x0, or rs2_used=0 -> no stall.
//  T3 BR_PENALTY=2, branch pulse in RUN
//     -> cycle0 if_id_flush=id_exe_flush=1; cycle1 if_id_flush=1 only; cycle2 defaults.
//  T4 branch accepted, then mem_busy high 3 cycles during FLUSH
//     -> pipe_hold=1 x3, then 1 remaining if_id_flush cycle, then RUN.
//  T5 WAIT_MAX=4, mem_busy high 6 cycles -> wait_timeout=1 from cycle 5, stays 1 after busy drops.
//  T6 rst asserted mid-FLUSH, with HAZARD_PERF_CNT_EN defined
//     -> next cycle RUN, perf counters 0, no residual flush.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//  Bundles the hazard-detection inputs coming from the ID/EXE/memory stages
//  and the stall/flush controls going back to the pipeline registers.
//  Modports:
//   master : pipeline side, drives the hazard inputs, receives the controls
//   slave  : hazard_ctrl side, samples the hazard inputs, drives the controls
//  Signals:
//   id_rs1_addr/id_rs2_addr [4:0]  source registers of the ID instruction
//   id_rs1_used/id_rs2_used        ID instruction really reads rs1/rs2
//   id_exe_mem_read                instruction in EXE is a load
//   id_exe_rd_addr [4:0]           destination register of the EXE instruction
//   exe_branch_taken               EXE resolved a taken branch/jump (pulse)
//   mem_busy                       IM or DM not ready this cycle
//   pc_write/if_id_write           PC and IF_ID write enables
//   if_id_flush/id_exe_flush       bubble injection into IF_ID / ID_EXE
//   pipe_hold                      freeze every pipeline register
//   wait_timeout                   sticky memory-wait watchdog flag
interface hazard_ctrl_if;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic       id_exe_mem_read;
    logic [4:0] id_exe_rd_addr;
    logic       exe_branch_taken;
    logic       mem_busy;

    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_exe_flush;
    logic       pipe_hold;
    logic       wait_timeout;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_exe_mem_read, id_exe_rd_addr, exe_branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_exe_flush,
               pipe_hold, wait_timeout
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_exe_mem_read, id_exe_rd_addr, exe_branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_exe_flush,
               pipe_hold, wait_timeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//  Pipeline hazard/stall controller for the 5-stage RV32 core. Handles the
//  cases the forwarding unit cannot: load-use (1-cycle bubble), taken-branch
//  flush (BR_PENALTY cycles of IF/ID kill) and memory back-pressure (whole
//  pipe freeze with a sticky wait watchdog).
//  Parameters:
//   BR_PENALTY (1..7)   cycles IF/ID is killed after a taken branch
//   WAIT_MAX   (1..255) busy cycles tolerated before wait_timeout sets
//  Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   hz                  hazard_ctrl_if.slave (hazard inputs, stall/flush outputs)
//   perf_stall_cnt/perf_flush_cnt [31:0]  only when HAZARD_PERF_CNT_EN is defined
//  Configuration macro: HAZARD_PERF_CNT_EN adds the two performance counters.
module hazard_ctrl #(
    parameter int unsigned BR_PENALTY = 2,
    parameter int unsigned WAIT_MAX   = 255
) (
    input  logic        clk,
    input  logic        rst,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    hazard_ctrl_if.slave hz
);

    localparam logic [2:0] BR_INIT  = 3'(BR_PENALTY - 1);
    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

    state_t     state, state_nxt;
    state_t     ret_state, ret_nxt;
    state_t     dec_state;
    logic [2:0] flush_cnt, flush_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       wait_timeout, timeout_nxt;
    logic       lu;

    logic pc_write_o, if_id_write_o, if_id_flush_o, id_exe_flush_o, pipe_hold_o;

    assign lu = hz.id_exe_mem_read && (hz.id_exe_rd_addr != 5'd0) &&
                ((hz.id_rs1_used && (hz.id_rs1_addr == hz.id_exe_rd_addr)) ||
                 (hz.id_rs2_used && (hz.id_rs2_addr == hz.id_exe_rd_addr)));

    // Output decode and next-state logic. The cycle that leaves MEM_WAIT is
    // decoded exactly as a cycle of the state we return to, so a branch that
    // was frozen in EXE is accepted (and its flush sequence started) there.
    // wait_cnt counts consecutive busy cycles including the one that entered
    // MEM_WAIT, so wait_timeout sets after WAIT_MAX+1 busy cycles.
    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_exe_flush_o = 1'b0;
        pipe_hold_o    = 1'b0;
        state_nxt      = state;
        ret_nxt        = ret_state;
        flush_nxt      = flush_cnt;
        wait_nxt       = wait_cnt;
        timeout_nxt    = wait_timeout;
        dec_state      = state;

        if (state == MEM_WAIT) begin
            if (hz.mem_busy) begin
                pipe_hold_o   = 1'b1;
                pc_write_o    = 1'b0;
                if_id_write_o = 1'b0;
                if (wait_cnt != 8'hFF) begin
                    wait_nxt = wait_cnt + 8'd1;
                end
                if (wait_cnt == WAIT_LIM) begin
                    timeout_nxt = 1'b1;
                end
            end else begin
                wait_nxt  = 8'd0;
                dec_state = ret_state;
                state_nxt = ret_state;
            end
        end

        case (dec_state)
            RUN, FLUSH: begin
                if (hz.mem_busy) begin
                    pipe_hold_o   = 1'b1;
                    pc_write_o    = 1'b0;
                    if_id_write_o = 1'b0;
                    ret_nxt       = dec_state;
                    state_nxt     = MEM_WAIT;
                    wait_nxt      = 8'd1;
                end else if (hz.exe_branch_taken) begin
                    if_id_flush_o  = 1'b1;
                    id_exe_flush_o = 1'b1;
                    flush_nxt      = BR_INIT;
                    state_nxt      = (BR_PENALTY > 1) ? FLUSH : RUN;
                end else if (dec_state == RUN) begin
                    if (lu) begin
                        pc_write_o     = 1'b0;
                        if_id_write_o  = 1'b0;
                        id_exe_flush_o = 1'b1;
                    end
                end else begin
                    if_id_flush_o = 1'b1;
                    if (flush_cnt <= 3'd1) begin
                        flush_nxt = 3'd0;
                        state_nxt = RUN;
                    end else begin
                        flush_nxt = flush_cnt - 3'd1;
                    end
                end
            end
            default: ;
        endcase

        if (rst) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            if_id_flush_o  = 1'b1;
            id_exe_flush_o = 1'b1;
            pipe_hold_o    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            ret_state    <= RUN;
            flush_cnt    <= 3'd0;
            wait_cnt     <= 8'd0;
            wait_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            ret_state    <= ret_nxt;
            flush_cnt    <= flush_nxt;
            wait_cnt     <= wait_nxt;
            wait_timeout <= timeout_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Outside reset, pc_write is low only for a freeze or a load-use stall,
    // and if_id_flush together with id_exe_flush only marks a branch accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (!pc_write_o) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (if_id_flush_o && id_exe_flush_o) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

    assign hz.pc_write     = pc_write_o;
    assign hz.if_id_write  = if_id_write_o;
    assign hz.if_id_flush  = if_id_flush_o;
    assign hz.id_exe_flush = id_exe_flush_o;
    assign hz.pipe_hold    = pipe_hold_o;
    assign hz.wait_timeout = wait_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//  Drives hazard_ctrl through directed hazard scenarios followed by random
//  traffic, comparing every cycle against a behavioural model that tracks
//  only "flush cycles left", "consecutive busy cycles" and the sticky flag.
module tb_hazard_ctrl;
    localparam int BR_PEN = 2;
    localparam int WMAX   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_ctrl_if hif();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    hazard_ctrl #(.BR_PENALTY(BR_PEN), .WAIT_MAX(WMAX)) dut (
        .clk(clk),
        .rst(rst),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt),
`endif
        .hz(hif)
    );

    int compared   = 0;
    int mismatched = 0;

    // Behavioural reference state
    int          flush_left = 0;
    int          busy_run   = 0;
    bit          tmo        = 1'b0;
    int unsigned m_stall    = 0;
    int unsigned m_flush    = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        compared++;
        if (got !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare the
    // combinational outputs shortly after, then advance the model to match
    // the coming rising edge.
    task automatic applyStimulus(input string tag, input bit r, input bit mb, input bit br,
                                 input bit mr, input logic [4:0] rd,
                                 input logic [4:0] rs1, input bit u1,
                                 input logic [4:0] rs2, input bit u2);
        logic [5:0] expv;
        logic [5:0] got;
        bit         lu;
        @(negedge clk);
        rst                  = r;
        hif.mem_busy         = mb;
        hif.exe_branch_taken = br;
        hif.id_exe_mem_read  = mr;
        hif.id_exe_rd_addr   = rd;
        hif.id_rs1_addr      = rs1;
        hif.id_rs1_used      = u1;
        hif.id_rs2_addr      = rs2;
        hif.id_rs2_used      = u2;
        #2;
        lu = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        // {pc_write, if_id_write, if_id_flush, id_exe_flush, pipe_hold, wait_timeout}
        if (r)                   expv = {5'b00110, tmo};
        else if (mb)             expv = {5'b00001, tmo};
        else if (br)             expv = {5'b11110, tmo};
        else if (flush_left > 0) expv = {5'b11100, tmo};
        else if (lu)             expv = {5'b00010, tmo};
        else                     expv = {5'b11000, tmo};
        got = {hif.pc_write, hif.if_id_write, hif.if_id_flush,
               hif.id_exe_flush, hif.pipe_hold, hif.wait_timeout};
        checkOutput(tag, 32'(got), 32'(expv));
`ifdef HAZARD_PERF_CNT_EN
        checkOutput({tag, "/stall_cnt"}, perf_stall_cnt, m_stall);
        checkOutput({tag, "/flush_cnt"}, perf_flush_cnt, m_flush);
`endif
        if (r) begin
            flush_left = 0;
            busy_run   = 0;
            tmo        = 1'b0;
            m_stall    = 0;
            m_flush    = 0;
        end else if (mb) begin
            busy_run++;
            if (busy_run > WMAX) tmo = 1'b1;
            m_stall++;
        end else begin
            busy_run = 0;
            if (br) begin
                flush_left = BR_PEN - 1;
                m_flush++;
            end else if (flush_left > 0) begin
                flush_left--;
            end else if (lu) begin
                m_stall++;
            end
        end
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        hif.mem_busy         = 1'b0;
        hif.exe_branch_taken = 1'b0;
        hif.id_exe_mem_read  = 1'b0;
        hif.id_exe_rd_addr   = 5'd0;
        hif.id_rs1_addr      = 5'd0;
        hif.id_rs1_used      = 1'b0;
        hif.id_rs2_addr      = 5'd0;
        hif.id_rs2_used      = 1'b0;
        rst                  = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] reset and idle");
        applyStimulus("rst_forced", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idleCycle("after_rst");

        $display("[TB] load-use");
        applyStimulus("T1_stall", 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
        idleCycle("T1_next");
        applyStimulus("T2_rd_x0", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        applyStimulus("T2_rs2_unused", 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0);
        applyStimulus("T1_rs1_hit", 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd2, 1'b0);

        $display("[TB] branch flush");
        applyStimulus("T3_c0", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus("T3_c1_lu_ignored", 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
        idleCycle("T3_c2");

        $display("[TB] branch then memory wait");
        applyStimulus("T4_br", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("T4_hold%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idleCycle("T4_last_flush");
        idleCycle("T4_run");

        $display("[TB] wait watchdog");
        for (int i = 0; i < 6; i++)
            applyStimulus($sformatf("T5_busy%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idleCycle("T5_sticky0");
        idleCycle("T5_sticky1");

        $display("[TB] reset mid-flush");
        applyStimulus("T6_br", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus("T6_rst", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idleCycle("T6_run");
        idleCycle("T6_run2");

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            applyStimulus($sformatf("rand%0d", i),
                          $urandom_range(99) < 2,
                          $urandom_range(99) < 20,
                          $urandom_range(99) < 15,
                          $urandom_range(99) < 40,
                          5'($urandom_range(3)),
                          5'($urandom_range(3)), 1'($urandom_range(1)),
                          5'($urandom_range(3)), 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
